vga_frame_sequencer: RTL and testbench
======================================

// Module: vga_frame_sequencer
// PURPOSE
//  Sets the window parameters for the VGA display path: width, height, rev, fl and the flash clock pulse05H.
//  Takes four raw push buttons (grow, shrink, reverse, flash) and an auto-demo toggle.
//  All changes are staged and committed on a v_sync rising edge, so a frame never shows a torn or half-updated window.
//  Sits between the board buttons and vga_controller, in the pulse25M domain.
// PARAMETERS
//  DB_CYCLES   250000    debounce stable time, in clocks (10 ms at 25 MHz)
//  HALF_PERIOD 25000000  clocks per pulse05H half-period (0.5 Hz square wave)
//  STEP_W      16        width increment/decrement per step
//  STEP_H      10        height increment/decrement per step
//  W_MIN/W_MAX 48/624    width clamp; W_MAX keeps the 5-pixel border inside 640
//  H_MIN/H_MAX 30/380    height clamp; H_MAX keeps the border inside 400 rows
//  W_RST/H_RST 320/200   width/height after reset
//  AUTO_FRAMES 8         frames between automatic steps in auto mode
// PORTS
//  pulse25M   in   1   pixel clock, 25 MHz
//  reset      in   1   asynchronous reset, active-low
//  btn_grow   in   1   raw button, active-high, asynchronous
//  btn_shrink in   1   raw button
//  btn_rev    in   1   raw button; toggles rev
//  btn_fl     in   1   raw button; toggles fl
//  btn_auto   in   1   raw button; toggles auto mode
//  v_sync     in   1   from vga_controller; active-high pulse once per frame
//  width      out  10  window width to vga_controller
//  height     out  9   window height to vga_controller
//  rev        out  1   reverse-video enable
//  fl         out  1   flash enable
//  pulse05H   out  1   0.5 Hz square wave
//  auto_on    out  1   auto mode active
//  pending    out  1   a change is staged and waiting for the frame edge
// BEHAVIOUR
//  Reset (reset=0, async): width=W_RST, height=H_RST; rev=fl=auto_on=pending=pulse05H=0; FSM=IDLE; all counters=0.
//  Button path:
//   - Each button passes through a 2-flop synchronizer and a debouncer.
//   - The debounced output changes only after DB_CYCLES consecutive equal samples.
//   - The debounced rising edge gives a 1-clock press pulse, 2+DB_CYCLES+1 clocks after a stable input.
//  v_sync rising edge is detected with a 1-flop delay; this gives frame_tick (1 clock).
//  Staging registers: dir (-1/0/+1), tog_rev, tog_fl.
//   - grow press: dir+1, saturating at +1.
//   - shrink press: dir-1, saturating at -1. So grow then shrink in one frame nets to 0.
//   - grow and shrink pressed in the same cycle: no change to dir.
//   - rev/fl press: XOR into tog_rev/tog_fl. Two presses in one frame cancel.
//   - In auto mode, grow/shrink presses are ignored.
//  pending = (dir!=0)|tog_rev|tog_fl.
//  FSM (states belong in the package):
//   - IDLE: pending=1 -> ARMED.
//   - ARMED: frame_tick -> APPLY; staging cleared to zero before frame_tick -> IDLE.
//   - APPLY (1 clock): commit, clear all staging, -> IDLE.
//   - A press arriving in the APPLY cycle is staged for the next frame and is not lost.
//  Commit arithmetic:
//   - width += dir*STEP_W, then clamp to [W_MIN,W_MAX]. Compute in 11-bit signed; no wrap-around allowed.
//   - height likewise with STEP_H and [H_MIN,H_MAX], in 10-bit signed.
//   - rev ^= tog_rev; fl ^= tog_fl.
//   - Outputs change only in the cycle after APPLY, then stay stable for the full frame.
//  Auto mode:
//   - btn_auto press toggles auto_on immediately. On entry, auto_dir=+1 and the frame counter is 0.
//   - Each frame_tick increments the frame counter. When it reaches AUTO_FRAMES-1, the counter wraps to 0 and dir is set to auto_dir.
//   - If a commit reaches W_MAX or H_MAX, auto_dir becomes -1. If it reaches W_MIN or H_MIN, auto_dir becomes +1 (ping-pong).
//   - Leaving auto mode clears dir; a staged rev/fl toggle is kept.
//  pulse05H: a counter over 0..HALF_PERIOD-1; pulse05H toggles on wrap. Free-running, independent of the FSM.
//  Reset mid-frame or mid-debounce discards every staged and in-flight change.
// STRUCTURE
//  Package vga_seq_pkg:
//   - FSM state enum {IDLE,ARMED,APPLY}.
//   - Clamp and step constants.
//   - The 640x400 visible-area constants, shared with vga_controller.
//  Sub-module button_debouncer (synchronizer + DB_CYCLES counter + edge pulse), instantiated 5 times.
//  Top level holds the staging registers, FSM, clamp arithmetic, auto counter and flash divider.
// TESTING (DB_CYCLES=4, HALF_PERIOD=8, AUTO_FRAMES=2, v_sync pulse every 100 clocks)
//  1. Reset, no stimulus -> width=320, height=200, rev=fl=0. pulse05H toggles every 8 clocks.
//  2. grow press mid-frame -> pending=1, width unchanged until the next v_sync edge, then width=336, height=210.
//  3. Glitch of btn_grow high for 2 clocks -> no press, pending stays 0.
//     grow+shrink in one frame -> no change, FSM back in IDLE.
//  4. width=608, grow x3 over 3 frames -> 624, 624, 624 (clamped). Symmetric check at W_MIN=48.
//  5. rev pressed twice in one frame -> rev stays 0. rev once -> rev=1 exactly at the frame edge.
//  6. auto on from 320x200 -> +1 step every 2 frames, reversing at the clamp.
//     Assert reset mid-frame with a staged change -> all outputs return to reset values.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// Shared constants and FSM state type for the VGA frame sequencer.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2
  } seq_state_e;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 400;

  localparam logic [9:0] STEP_W = 10'd16;
  localparam logic [8:0] STEP_H = 9'd10;

  // Largest step-aligned window that still leaves the 5-pixel border visible.
  localparam logic [9:0] W_MAX = 10'(H_VISIBLE - 16);
  localparam logic [8:0] H_MAX = 9'(V_VISIBLE - 20);
  localparam logic [9:0] W_MIN = 10'd48;
  localparam logic [8:0] H_MIN = 9'd30;
  localparam logic [9:0] W_RST = 10'd320;
  localparam logic [8:0] H_RST = 9'd200;

endpackage

// File: rtl/button_debouncer.sv
// Raw button to single-clock press pulse: 2-flop synchronizer, stable-time
// debouncer and rising-edge detector on the debounced level.
module button_debouncer #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounced level follows the synchronized input after DB_CYCLES differing samples.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = db_q & ~db_prev_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vga_frame_sequencer.sv
// Stages window size / reverse / flash changes from debounced buttons and
// commits them on the v_sync rising edge; also runs auto-demo and the flash clock.
module vga_frame_sequencer #(
  parameter int DB_CYCLES   = 250000,
  parameter int HALF_PERIOD = 25000000,
  parameter int AUTO_FRAMES = 8
) (
  input  logic       pulse25M,
  input  logic       reset,
  input  logic       btn_grow,
  input  logic       btn_shrink,
  input  logic       btn_rev,
  input  logic       btn_fl,
  input  logic       btn_auto,
  input  logic       v_sync,
  output logic [9:0] width,
  output logic [8:0] height,
  output logic       rev,
  output logic       fl,
  output logic       pulse05H,
  output logic       auto_on,
  output logic       pending
);
  import vga_seq_pkg::*;

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int FW = $clog2(AUTO_FRAMES) + 1;

  logic [4:0] btn_raw_s, press_s;
  logic       grow_s, shrink_s, rev_p_s, fl_p_s, auto_p_s;
  logic       frame_tick_s, pending_s;

  seq_state_e         state_q, state_d;
  logic signed [1:0]  dir_q, dir_d, auto_dir_q, auto_dir_d;
  logic               tog_rev_q, tog_rev_d, tog_fl_q, tog_fl_d;
  logic [9:0]         width_q, width_d;
  logic [8:0]         height_q, height_d;
  logic               rev_q, rev_d, fl_q, fl_d, auto_on_q, auto_on_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [PW-1:0]      hp_cnt_q, hp_cnt_d;
  logic               pulse_q, pulse_d;
  logic               vs_q, tick_q;

  logic signed [10:0] w_sum_s;
  logic signed [9:0]  h_sum_s;
  logic [9:0]         w_clamp_s;
  logic [8:0]         h_clamp_s;

  assign btn_raw_s = {btn_auto, btn_fl, btn_rev, btn_shrink, btn_grow};

  for (genvar gi = 0; gi < 5; gi++) begin : g_db
    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (pulse25M),
      .rst_n   (reset),
      .btn_i   (btn_raw_s[gi]),
      .press_o (press_s[gi])
    );
  end

  assign grow_s   = press_s[0];
  assign shrink_s = press_s[1];
  assign rev_p_s  = press_s[2];
  assign fl_p_s   = press_s[3];
  assign auto_p_s = press_s[4];

  assign frame_tick_s = v_sync & ~vs_q;
  assign pending_s    = (dir_q != 2'sb00) | tog_rev_q | tog_fl_q;

  // Next window size: signed step then clamp, so no step can wrap.
  always_comb begin
    case (dir_q)
      2'sb01: begin
        w_sum_s = $signed({1'b0, width_q}) + $signed({1'b0, STEP_W});
        h_sum_s = $signed({1'b0, height_q}) + $signed({1'b0, STEP_H});
      end
      2'sb11: begin
        w_sum_s = $signed({1'b0, width_q}) - $signed({1'b0, STEP_W});
        h_sum_s = $signed({1'b0, height_q}) - $signed({1'b0, STEP_H});
      end
      default: begin
        w_sum_s = $signed({1'b0, width_q});
        h_sum_s = $signed({1'b0, height_q});
      end
    endcase
    if (w_sum_s > $signed({1'b0, W_MAX})) begin
      w_clamp_s = W_MAX;
    end else if (w_sum_s < $signed({1'b0, W_MIN})) begin
      w_clamp_s = W_MIN;
    end else begin
      w_clamp_s = w_sum_s[9:0];
    end
    if (h_sum_s > $signed({1'b0, H_MAX})) begin
      h_clamp_s = H_MAX;
    end else if (h_sum_s < $signed({1'b0, H_MIN})) begin
      h_clamp_s = H_MIN;
    end else begin
      h_clamp_s = h_sum_s[8:0];
    end
  end

  // FSM, commit, staging, auto schedule and flash divider.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tog_rev_d  = tog_rev_q;
    tog_fl_d   = tog_fl_q;
    width_d    = width_q;
    height_d   = height_q;
    rev_d      = rev_q;
    fl_d       = fl_q;
    auto_on_d  = auto_on_q;
    auto_dir_d = auto_dir_q;
    fcnt_d     = fcnt_q;
    hp_cnt_d   = hp_cnt_q;
    pulse_d    = pulse_q;

    case (state_q)
      S_IDLE:  state_d = pending_s ? S_ARMED : S_IDLE;
      S_ARMED: begin
        if (frame_tick_s) begin
          state_d = S_APPLY;
        end else if (!pending_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_APPLY) begin
      width_d   = w_clamp_s;
      height_d  = h_clamp_s;
      rev_d     = rev_q ^ tog_rev_q;
      fl_d      = fl_q ^ tog_fl_q;
      dir_d     = 2'sb00;
      tog_rev_d = 1'b0;
      tog_fl_d  = 1'b0;
      if ((w_clamp_s == W_MAX) || (h_clamp_s == H_MAX)) begin
        auto_dir_d = 2'sb11;
      end else if ((w_clamp_s == W_MIN) || (h_clamp_s == H_MIN)) begin
        auto_dir_d = 2'sb01;
      end else begin
        auto_dir_d = auto_dir_q;
      end
    end else begin
      width_d = width_q;
    end

    if (grow_s && !shrink_s && !auto_on_q) begin
      dir_d = (dir_d != 2'sb01) ? dir_d + 2'sb01 : dir_d;
    end else if (shrink_s && !grow_s && !auto_on_q) begin
      dir_d = (dir_d != 2'sb11) ? dir_d - 2'sb01 : dir_d;
    end else begin
      dir_d = dir_d;
    end
    tog_rev_d = tog_rev_d ^ rev_p_s;
    tog_fl_d  = tog_fl_d ^ fl_p_s;

    // Auto step lands one clock after the tick so an APPLY clear cannot drop it.
    if (auto_on_q && tick_q) begin
      if (fcnt_q == FW'(AUTO_FRAMES - 1)) begin
        fcnt_d = '0;
        dir_d  = auto_dir_d;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d = fcnt_d;
    end

    if (auto_p_s) begin
      auto_on_d = ~auto_on_q;
      if (auto_on_q) begin
        dir_d = 2'sb00;
      end else begin
        auto_dir_d = 2'sb01;
        fcnt_d     = '0;
      end
    end else begin
      auto_on_d = auto_on_q;
    end

    if (hp_cnt_q == PW'(HALF_PERIOD - 1)) begin
      hp_cnt_d = '0;
      pulse_d  = ~pulse_q;
    end else begin
      hp_cnt_d = hp_cnt_q + PW'(1);
    end
  end

  // State registers.
  always_ff @(posedge pulse25M or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dir_q      <= 2'sb00;
      tog_rev_q  <= 1'b0;
      tog_fl_q   <= 1'b0;
      width_q    <= W_RST;
      height_q   <= H_RST;
      rev_q      <= 1'b0;
      fl_q       <= 1'b0;
      auto_on_q  <= 1'b0;
      auto_dir_q <= 2'sb01;
      fcnt_q     <= '0;
      hp_cnt_q   <= '0;
      pulse_q    <= 1'b0;
      vs_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tog_rev_q  <= tog_rev_d;
      tog_fl_q   <= tog_fl_d;
      width_q    <= width_d;
      height_q   <= height_d;
      rev_q      <= rev_d;
      fl_q       <= fl_d;
      auto_on_q  <= auto_on_d;
      auto_dir_q <= auto_dir_d;
      fcnt_q     <= fcnt_d;
      hp_cnt_q   <= hp_cnt_d;
      pulse_q    <= pulse_d;
      vs_q       <= v_sync;
      tick_q     <= frame_tick_s;
    end
  end

  assign width    = width_q;
  assign height   = height_q;
  assign rev      = rev_q;
  assign fl       = fl_q;
  assign pulse05H = pulse_q;
  assign auto_on  = auto_on_q;
  assign pending  = pending_s;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Randomized frame-level bench for vga_frame_sequencer against a behavioural model.
module tb_vga_frame_sequencer;

  localparam int DB = 4;
  localparam int HP = 8;
  localparam int AF = 2;

  logic       pulse25M = 1'b0;
  logic       reset = 1'b0;
  logic       btn_grow = 1'b0, btn_shrink = 1'b0, btn_rev = 1'b0, btn_fl = 1'b0, btn_auto = 1'b0;
  logic       v_sync = 1'b0;
  logic [9:0] width;
  logic [8:0] height;
  logic       rev, fl, pulse05H, auto_on, pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: committed outputs, staging, auto mode.
  int m_w, m_h, m_rev, m_fl, m_auto, m_dir, m_auto_dir, m_fcnt, m_trev, m_tfl;

  vga_frame_sequencer #(.DB_CYCLES(DB), .HALF_PERIOD(HP), .AUTO_FRAMES(AF)) dut (
    .pulse25M   (pulse25M),
    .reset      (reset),
    .btn_grow   (btn_grow),
    .btn_shrink (btn_shrink),
    .btn_rev    (btn_rev),
    .btn_fl     (btn_fl),
    .btn_auto   (btn_auto),
    .v_sync     (v_sync),
    .width      (width),
    .height     (height),
    .rev        (rev),
    .fl         (fl),
    .pulse05H   (pulse05H),
    .auto_on    (auto_on),
    .pending    (pending)
  );

  always #5 pulse25M = ~pulse25M;

  // Clocks elapsed since reset release, for the flash-clock expectation.
  always @(posedge pulse25M or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_w = 320; m_h = 200; m_rev = 0; m_fl = 0; m_auto = 0;
    m_dir = 0; m_auto_dir = 1; m_fcnt = 0; m_trev = 0; m_tfl = 0;
  endtask

  // codes: 1 grow, 2 shrink, 3 rev, 4 fl, 5 auto; others stage nothing
  task automatic model_press(input int code);
    case (code)
      1: if (!m_auto && m_dir < 1) m_dir++;
      2: if (!m_auto && m_dir > -1) m_dir--;
      3: m_trev ^= 1;
      4: m_tfl ^= 1;
      5: begin
        if (m_auto != 0) begin
          m_auto = 0; m_dir = 0;
        end else begin
          m_auto = 1; m_auto_dir = 1; m_fcnt = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_tick();
    if (m_dir != 0 || m_trev != 0 || m_tfl != 0) begin
      m_w = clampi(m_w + 16 * m_dir, 48, 624);
      m_h = clampi(m_h + 10 * m_dir, 30, 380);
      m_rev ^= m_trev;
      m_fl ^= m_tfl;
      m_dir = 0; m_trev = 0; m_tfl = 0;
      if (m_w == 624 || m_h == 380) m_auto_dir = -1;
      else if (m_w == 48 || m_h == 30) m_auto_dir = 1;
    end
    if (m_auto != 0) begin
      if (m_fcnt == AF - 1) begin
        m_fcnt = 0; m_dir = m_auto_dir;
      end else begin
        m_fcnt++;
      end
    end
  endtask

  task automatic check_all();
    check_eq("width",    int'(width),    m_w);
    check_eq("height",   int'(height),   m_h);
    check_eq("rev",      int'(rev),      m_rev);
    check_eq("fl",       int'(fl),       m_fl);
    check_eq("auto_on",  int'(auto_on),  m_auto);
    check_eq("pending",  int'(pending),  int'(m_dir != 0 || m_trev != 0 || m_tfl != 0));
    check_eq("pulse05H", int'(pulse05H), (cyc / HP) % 2);
  endtask

  // One 100-clock frame; up to three actions start at phases 10, 30, 50.
  // codes 6 = grow+shrink together, 7 = 2-clock grow glitch, 8 = reset mid-debounce.
  task automatic run_frame(input int a0, input int a1, input int a2);
    int acts[3];
    int first_valid;
    acts = '{a0, a1, a2};
    first_valid = 0;
    for (int p = 0; p < 100; p++) begin
      @(negedge pulse25M);
      v_sync = (p < 4);
      btn_grow = 1'b0; btn_shrink = 1'b0; btn_rev = 1'b0; btn_fl = 1'b0; btn_auto = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
        int s;
        bit on;
        s = 10 + 20 * k;
        on = (p >= s) && (p < s + 8);
        case (acts[k])
          1: if (on) btn_grow = 1'b1;
          2: if (on) btn_shrink = 1'b1;
          3: if (on) btn_rev = 1'b1;
          4: if (on) btn_fl = 1'b1;
          5: if (on) btn_auto = 1'b1;
          6: if (on) begin btn_grow = 1'b1; btn_shrink = 1'b1; end
          7: if (p >= s && p < s + 2) btn_grow = 1'b1;
          8: begin
            if (p >= s && p < s + 3) btn_grow = 1'b1;
            if (p >= s + 3 && p < s + 6) reset = 1'b0;
          end
          default: ;
        endcase
        if (acts[k] == 8 && p == s + 4) begin
          model_reset();
          first_valid = k + 1;
          check_all();
        end
      end
      if (p == 1) begin
        check_eq("width_hold",  int'(width),  m_w);
        check_eq("height_hold", int'(height), m_h);
        model_tick();
      end
      if (p % 20 == 5) check_eq("pulse_run", int'(pulse05H), (cyc / HP) % 2);
      if (p == 85) begin
        for (int k = first_valid; k < 3; k++) model_press(acts[k]);
        check_all();
      end
    end
  endtask

  function automatic int rand_code(input bit with_auto);
    int pool[7];
    pool = '{0, 1, 2, 3, 4, 6, 7};
    if (with_auto && $urandom_range(0, 15) == 0) return 5;
    return pool[$urandom_range(0, 6)];
  endfunction

  function automatic int rand_toggle();
    int pool[3];
    pool = '{0, 3, 4};
    return pool[$urandom_range(0, 2)];
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge pulse25M);
    check_all();
    reset = 1'b1;

    run_frame(1, 0, 0);
    run_frame(0, 0, 0);
    run_frame(7, 0, 0);
    run_frame(1, 2, 0);
    run_frame(6, 0, 0);
    repeat (20) run_frame(1, 0, 0);
    repeat (40) run_frame(2, 0, 0);
    run_frame(3, 3, 0);
    run_frame(3, 0, 0);
    run_frame(4, 0, 0);
    repeat (40) run_frame(rand_code(1'b0), rand_code(1'b0), rand_code(1'b0));

    run_frame(1, 8, 0);
    run_frame(5, 0, 0);
    repeat (80) run_frame(rand_toggle(), 0, rand_toggle());
    run_frame(1, 5, 0);
    repeat (30) run_frame(rand_code(1'b1), rand_code(1'b1), rand_code(1'b1));
    run_frame(3, 1, 8);
    run_frame(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
